decode_stage: RTL and testbench

- Parametrised, handshaked successor to the single-cycle instruction decode stage.
- Accepts one instruction per valid/ready transfer and issues read requests to the register file (two ports) and data memory, both of which have a 1-cycle synchronous read latency.
- Captures the returned operands into registers and presents opcode, mode, op1 and op2 to the execute stage under valid/ready, stalling on downstream backpressure.
- Sits between instruction fetch and execute.

---
 rtl/decode_stage.sv | 157 +++++++++++++++
 tb/tb_decode_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Purpose : decode stage; reads regfile/data memory for one instruction and issues an operand bundle to execute.
// Latency : handshake cycle N -> READ (N+1) -> WAIT (N+2) -> out_valid in N+3; initiation interval 3 cycles.
// Backpr. : out_ready low holds the bundle and drops in_ready; a new instruction is taken on the releasing cycle.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready, instruction  fetch side: opcode | mode[1:0] | rs1 | imm (rs2 = imm MSBs)
//   reg_rd_en1/2, reg_id1/2         register-file read ports, data returns 1 cycle later on reg_data1/2
//   mem_rd_en, mem_addr, mem_data   data-memory read port, data returns 1 cycle later
//   out_valid/out_ready             execute side, bundle = opcode, mode, op1, op2, illegal
//
// Build option: define DECODE_SIGN_EXT_EN to sign-extend the mode-10 immediate
// (zero-extended otherwise). mem_addr is always zero-extended.
module decode_stage #(
  parameter int OPCODE_W = 6,
  parameter int REG_ID_W = 4,
  parameter int IMM_W    = 12,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  localparam int INSTR_W = OPCODE_W + 2 + REG_ID_W + IMM_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instruction,
  output logic                reg_rd_en1,
  output logic [REG_ID_W-1:0] reg_id1,
  output logic                reg_rd_en2,
  output logic [REG_ID_W-1:0] reg_id2,
  input  logic [DATA_W-1:0]   reg_data1,
  input  logic [DATA_W-1:0]   reg_data2,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [1:0]          mode,
  output logic [DATA_W-1:0]   op1,
  output logic [DATA_W-1:0]   op2,
  output logic                illegal
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} state_t;

  state_t state;

  // Latched instruction: only the fields still needed after the read requests are issued.
  logic [OPCODE_W-1:0] q_opcode;
  logic [1:0]          q_mode;
  logic [IMM_W-1:0]    q_imm;

  // Field split of the incoming instruction.
  logic [OPCODE_W-1:0] in_opcode;
  logic [1:0]          in_mode;
  logic [REG_ID_W-1:0] in_rs1;
  logic [IMM_W-1:0]    in_imm;
  logic [REG_ID_W-1:0] in_rs2;

  assign in_opcode = instruction[INSTR_W-1 -: OPCODE_W];
  assign in_mode   = instruction[IMM_W+REG_ID_W +: 2];
  assign in_rs1    = instruction[IMM_W +: REG_ID_W];
  assign in_imm    = instruction[IMM_W-1:0];
  assign in_rs2    = in_imm[IMM_W-1 -: REG_ID_W];

  // Ready while empty, or while the held bundle is being consumed this cycle.
  assign in_ready = (state == IDLE) || ((state == OUT) && out_ready);

  logic accept;
  assign accept = in_valid && in_ready;

  logic [DATA_W-1:0] imm_ext;
`ifdef DECODE_SIGN_EXT_EN
  assign imm_ext = DATA_W'($signed(q_imm));
`else
  assign imm_ext = DATA_W'(q_imm);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      q_opcode   <= '0;
      q_mode     <= '0;
      q_imm      <= '0;
      reg_rd_en1 <= 1'b0;
      reg_id1    <= '0;
      reg_rd_en2 <= 1'b0;
      reg_id2    <= '0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      out_valid  <= 1'b0;
      opcode     <= '0;
      mode       <= '0;
      op1        <= '0;
      op2        <= '0;
      illegal    <= 1'b0;
    end else begin
      // Read enables are single-cycle pulses covering the READ state.
      reg_rd_en1 <= 1'b0;
      reg_rd_en2 <= 1'b0;
      mem_rd_en  <= 1'b0;

      if (accept) begin
        q_opcode   <= in_opcode;
        q_mode     <= in_mode;
        q_imm      <= in_imm;
        reg_rd_en1 <= 1'b1;
        reg_id1    <= in_rs1;
        // reg_id2 / mem_addr are only updated when their enable fires.
        case (in_mode)
          2'b00: begin
            reg_rd_en2 <= 1'b1;
            reg_id2    <= in_rs2;
          end
          2'b01: begin
            mem_rd_en <= 1'b1;
            mem_addr  <= ADDR_W'(in_imm);
          end
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (accept) state <= READ;
        end
        READ: begin
          state <= WAIT;
        end
        WAIT: begin
          // Read data from the requests issued in READ is valid now.
          op1 <= reg_data1;
          case (q_mode)
            2'b00:   op2 <= reg_data2;
            2'b01:   op2 <= mem_data;
            2'b10:   op2 <= imm_ext;
            default: op2 <= '0;
          endcase
          opcode    <= q_opcode;
          mode      <= q_mode;
          illegal   <= (q_mode == 2'b11);
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? READ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  localparam int INSTR_W = 24;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] instruction;
  logic        reg_rd_en1, reg_rd_en2, mem_rd_en;
  logic [3:0]  reg_id1, reg_id2;
  logic [15:0] reg_data1, reg_data2, mem_data, mem_addr;
  logic        out_valid, out_ready;
  logic [5:0]  opcode;
  logic [1:0]  mode;
  logic [15:0] op1, op2;
  logic        illegal;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .reg_rd_en1(reg_rd_en1), .reg_id1(reg_id1),
    .reg_rd_en2(reg_rd_en2), .reg_id2(reg_id2),
    .reg_data1(reg_data1), .reg_data2(reg_data2),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .mode(mode), .op1(op1), .op2(op2), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file and data memory with 1-cycle synchronous reads.
  logic [15:0] rf [16];
  logic [15:0] mem [4096];

  always @(posedge clk) begin
    if (reg_rd_en1) reg_data1 <= rf[reg_id1];
    if (reg_rd_en2) reg_data2 <= rf[reg_id2];
    if (mem_rd_en)  mem_data  <= mem[mem_addr[11:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [5:0]  opc;
    logic [1:0]  md;
    logic [15:0] o1;
    logic [15:0] o2;
    logic        ill;
    logic [31:0] acc;
  } out_t;

  typedef struct packed {
    logic        en2;
    logic [3:0]  id2;
    logic        men;
    logic [15:0] addr;
    logic [3:0]  id1;
  } rd_t;

  out_t out_q[$];
  rd_t  rd_q[$];

  // Read-port monitor: one expected read set per accepted instruction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_rd_en1) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", 64'(reg_rd_en1), 64'd0);
        end else begin
          rd_t e, g;
          e = rd_q.pop_front();
          g.en2  = reg_rd_en2;
          g.id2  = reg_rd_en2 ? reg_id2 : 4'd0;
          g.men  = mem_rd_en;
          g.addr = mem_rd_en ? mem_addr : 16'd0;
          g.id1  = reg_id1;
          chk("rd_ports", 64'(g), 64'(e));
        end
      end else if (reg_rd_en2 || mem_rd_en) begin
        chk("rd_orphan_en", 64'({reg_rd_en2, mem_rd_en}), 64'd0);
      end
    end
  end

  // Output monitor: checks arrival cycle on first sight, fields on handshake.
  bit arrived = 1'b0;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (out_q.size() == 0) begin
        chk("out_unexpected", 64'(out_valid), 64'd0);
      end else begin
        out_t e;
        e = out_q[0];
        if (!arrived) begin
          chk("latency", 64'(cyc), 64'(e.acc + 32'd3));
          arrived = 1'b1;
        end
        if (out_ready) begin
          chk("bundle", 64'({opcode, mode, op1, op2, illegal}),
                        64'({e.opc, e.md, e.o1, e.o2, e.ill}));
          void'(out_q.pop_front());
          arrived = 1'b0;
        end
      end
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [5:0] opc, input logic [1:0] md, input logic [3:0] rs1,
                      input logic [11:0] imm, input logic [15:0] e1, input logic [15:0] e2,
                      input bit want_out);
    bit ok;
    rd_t  r;
    out_t o;
    ok = 1'b0;
    in_valid    = 1'b1;
    instruction = {opc, md, rs1, imm};
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    else begin
      r.en2  = (md == 2'b00);
      r.id2  = (md == 2'b00) ? imm[11:8] : 4'd0;
      r.men  = (md == 2'b01);
      r.addr = (md == 2'b01) ? {4'h0, imm} : 16'd0;
      r.id1  = rs1;
      rd_q.push_back(r);
      if (want_out) begin
        o.opc = opc; o.md = md; o.o1 = e1; o.o2 = e2; o.ill = (md == 2'b11);
        o.acc = 32'(cyc);
        out_q.push_back(o);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (out_q.size() == 0 && rd_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(out_q.size() + rd_q.size()), 64'd0);
  endtask

  logic [15:0] exp_neg;

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h0100 + 16'(i);
    rf[0] = 16'hA000; rf[3] = 16'h1234; rf[5] = 16'h5555; rf[7] = 16'h00FF;
    mem[12'h0A5] = 16'hBEEF;
    mem[12'h0FF] = 16'h7777;
`ifdef DECODE_SIGN_EXT_EN
    exp_neg = 16'hFF80;
`else
    exp_neg = 16'h0F80;
`endif
    rst_n = 1'b0; in_valid = 1'b0; instruction = '0; out_ready = 1'b1;
    reg_data1 = '0; reg_data2 = '0; mem_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 64'({out_valid, illegal, reg_rd_en1, reg_rd_en2, mem_rd_en, opcode, mode,
                           op1, op2, reg_id1, reg_id2, mem_addr}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Back-to-back directed vectors, all modes.
    send(6'h05, 2'b00, 4'd3, 12'h700, 16'h1234, 16'h00FF, 1'b1);
    send(6'h11, 2'b01, 4'd3, 12'h0A5, 16'h1234, 16'hBEEF, 1'b1);
    send(6'h22, 2'b10, 4'd7, 12'hF80, 16'h00FF, exp_neg,  1'b1);
    send(6'h3F, 2'b11, 4'd5, 12'h123, 16'h5555, 16'h0000, 1'b1);
    send(6'h01, 2'b10, 4'd0, 12'h07F, 16'hA000, 16'h007F, 1'b1);
    drain();

    // Backpressure: hold for 5 cycles, then release with a new instruction in the same cycle.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(6'h0A, 2'b00, 4'd5, 12'h300, 16'h5555, 16'h1234, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    chk("bp_valid", 64'(out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", 64'({opcode, op1, op2, out_valid}), 64'({6'h0A, 16'h5555, 16'h1234, 1'b1}));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(6'h0B, 2'b01, 4'd7, 12'h0FF, 16'h00FF, 16'h7777, 1'b1);
    drain();

    // Reset asserted while in WAIT discards the instruction.
    @(posedge clk); #1;
    send(6'h2A, 2'b00, 4'd3, 12'h500, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", 64'({out_valid, illegal, reg_rd_en1, reg_rd_en2, mem_rd_en, opcode, mode,
                              op1, op2, reg_id1, reg_id2, mem_addr}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_valid_after_reset", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(6'h15, 2'b11, 4'd3, 12'hFFF, 16'h1234, 16'h0000, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
